hazard_stall_unit: RTL

Pipeline hazard controller that sits directly downstream of the D-stage AT decoder in the 5-stage MIPS core. It takes the decoded D-stage requirements (Tuse flags, A1/A2/A3, Res, Dchengchu) and carries A1/A2/A3/Res through E, M and W in its own shadow registers. From those registers it derives Tnew, stall and bubble requests, and forwarding-mux selects for D, E and M. It also holds the multiply/divide busy counter that stalls HI/LO instructions.

---
 rtl/hazard_stall_unit_pkg.sv | 54 +++++
 rtl/hazard_stall_unit_md_busy_ctr.sv | 26 ++
 rtl/hazard_stall_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings and helpers for the hazard/stall unit.
package hazard_stall_unit_pkg;

  // Result source codes, same encoding as the AT decoder.
  typedef enum logic [1:0] {
    RES_NW  = 2'd0,
    RES_ALU = 2'd1,
    RES_DM  = 2'd2,
    RES_PC8 = 2'd3
  } res_e;

  // Forward mux select codes.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_e;

  typedef enum logic [1:0] {
    STG_E = 2'd0,
    STG_M = 2'd1,
    STG_W = 2'd2
  } stg_e;

  // Destination part of a shadow stage entry.
  typedef struct packed {
    logic [4:0] a3;
    res_e       res;
  } dst_t;

  localparam dst_t DST_NONE = '{a3: 5'd0, res: RES_NW};

  // Cycles until the stage's result can be forwarded.
  function automatic logic [1:0] tnew(res_e res, stg_e stg);
    tnew = 2'd0;
    case (stg)
      STG_E:   tnew = (res == RES_ALU) ? 2'd1 : (res == RES_DM) ? 2'd2 : 2'd0;
      STG_M:   tnew = (res == RES_DM) ? 2'd1 : 2'd0;
      default: tnew = 2'd0;
    endcase
  endfunction

  // Stage writes a real register ($0 excluded) equal to src.
  function automatic logic hit(dst_t d, logic [4:0] src);
    hit = (d.a3 != 5'd0) && (d.res != RES_NW) && (d.a3 == src);
  endfunction

  // Forward priority E > M > W, register file otherwise.
  function automatic fwd_e prio(logic e, logic m, logic w);
    prio = e ? FWD_E : m ? FWD_M : w ? FWD_W : FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_ctr.sv
// Mult/div busy countdown; busy while the count is non-zero.
module md_busy_ctr #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Load on issue (wins over decrement), otherwise count down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (md_start)    cnt <= md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    else if (cnt != '0)   cnt <= cnt - CW'(1);
  end

  assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard controller: E/M/W shadow pipeline, stall and forward selects.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tuse_rs0,
  input  logic       Tuse_rs1,
  input  logic       Tuse_rt0,
  input  logic       Tuse_rt1,
  input  logic       Tuse_rt2,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [4:0] A3_D,
  input  logic [1:0] Res_D,
  input  logic       Dchengchu_D,
  input  logic       md_start_E,
  input  logic       md_is_div_E,
  output logic       stall,
  output logic       md_busy,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic [1:0] fwd_rt_M
);

  // Only the sources that are still consumed downstream are kept.
  logic [4:0] e_a1, e_a2, m_a2;
  dst_t       e_d, m_d, w_d;
  logic [1:0] tnew_e, tnew_m;
  logic       stall_data, stall_md;

  md_busy_ctr #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start_E),
    .md_is_div(md_is_div_E),
    .md_busy  (md_busy)
  );

  // Shadow pipeline; a stall turns the E load into a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_a1 <= '0;
      e_a2 <= '0;
      m_a2 <= '0;
      e_d  <= DST_NONE;
      m_d  <= DST_NONE;
      w_d  <= DST_NONE;
    end else begin
      if (stall) begin
        e_a1 <= '0;
        e_a2 <= '0;
        e_d  <= DST_NONE;
      end else begin
        e_a1 <= A1_D;
        e_a2 <= A2_D;
        e_d  <= '{a3: A3_D, res: res_e'(Res_D)};
      end
      m_a2 <= e_a2;
      m_d  <= e_d;
      w_d  <= m_d;
    end
  end

  assign tnew_e = tnew(e_d.res, STG_E);
  assign tnew_m = tnew(m_d.res, STG_M);

  // Data stall: a matching producer in E or M is later than the consumer
  // needs it. The Tuse=2 term can never fire (max Tnew is 2).
  always_comb begin
    stall_data = 1'b0;
    if (hit(e_d, A1_D) && ((Tuse_rs0 && tnew_e > 2'd0) || (Tuse_rs1 && tnew_e > 2'd1)))
      stall_data = 1'b1;
    if (hit(m_d, A1_D) && ((Tuse_rs0 && tnew_m > 2'd0) || (Tuse_rs1 && tnew_m > 2'd1)))
      stall_data = 1'b1;
    if (hit(e_d, A2_D) && ((Tuse_rt0 && tnew_e > 2'd0) || (Tuse_rt1 && tnew_e > 2'd1) ||
                           (Tuse_rt2 && tnew_e > 2'd2)))
      stall_data = 1'b1;
    if (hit(m_d, A2_D) && ((Tuse_rt0 && tnew_m > 2'd0) || (Tuse_rt1 && tnew_m > 2'd1) ||
                           (Tuse_rt2 && tnew_m > 2'd2)))
      stall_data = 1'b1;
  end

  assign stall_md = Dchengchu_D && (md_busy || md_start_E);
  assign stall    = stall_data || stall_md;

  // A stage forwards only once its value exists (Tnew = 0).
  assign fwd_rs_D = prio(hit(e_d, A1_D) && tnew_e == 2'd0,
                         hit(m_d, A1_D) && tnew_m == 2'd0, hit(w_d, A1_D));
  assign fwd_rt_D = prio(hit(e_d, A2_D) && tnew_e == 2'd0,
                         hit(m_d, A2_D) && tnew_m == 2'd0, hit(w_d, A2_D));
  assign fwd_rs_E = prio(1'b0, hit(m_d, e_a1) && tnew_m == 2'd0, hit(w_d, e_a1));
  assign fwd_rt_E = prio(1'b0, hit(m_d, e_a2) && tnew_m == 2'd0, hit(w_d, e_a2));
  assign fwd_rt_M = prio(1'b0, 1'b0, hit(w_d, m_a2));

endmodule
